bcd_to_bin_operand: RTL and testbench

//  Multi-cycle converter from packed 16-digit BCD keypad operand to 54-bit unsigned binary.

---
 rtl/calc_pkg.sv | 13 +
 rtl/bcd_mac10.sv | 21 ++
 rtl/bcd_to_bin_operand.sv | 128 ++++++++++++
 tb/tb_bcd_to_bin_operand.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: default operand sizing, BCD digit width and
// the converter state encoding. Also used by the binary-to-BCD display path.
package calc_pkg;

    localparam int DIGITS_DEF = 16;
    localparam int BIN_W_DEF  = 54;
    localparam int BCD_W      = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_mac10.sv
// One step of decimal-to-binary accumulation: acc*10 + digit, plus a flag
// raised when the incoming nibble is not a legal BCD digit.
module bcd_mac10
    import calc_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0] i_acc,
    input  logic [BCD_W-1:0] i_digit,
    output logic [BIN_W-1:0] o_accNext,
    output logic             o_digitBad
);

    // Shift-and-add multiply by ten; wrapping at BIN_W gives the same low bits as
    // computing wider and truncating on write-back.
    always_comb begin
        o_accNext  = (i_acc << 3) + (i_acc << 1) + BIN_W'(i_digit);
        o_digitBad = (i_digit > 4'd9);
    end

endmodule

// File: rtl/bcd_to_bin_operand.sv
// Multi-cycle packed-BCD to binary operand converter, one digit per clock,
// most significant digit first. Optional invalid-digit checking is enabled
// with the macro BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_operand
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_p,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SH_W  = BCD_W * DIGITS;

    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_acc;
    logic [SH_W-1:0]  r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [BIN_W-1:0] r_binOut;
    logic             r_flag;

    logic [BIN_W-1:0] w_accNext;
    logic             w_digitBad;
    logic [BCD_W-1:0] w_digit;

    assign w_digit = r_shreg[SH_W-1 -: BCD_W];

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .i_acc      (r_acc),
        .i_digit    (w_digit),
        .o_accNext  (w_accNext),
        .o_digitBad (w_digitBad)
    );

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_err;

    // Sticky bad-digit flag for the conversion in flight; cleared on accept.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_flag <= 1'b0;
        end else if (r_state == ST_IDLE && start && !r_done) begin
            r_flag <= 1'b0;
        end else if (r_state == ST_CONV && w_digitBad) begin
            r_flag <= 1'b1;
        end
    end

    // Error flag is published together with the result and held alongside it.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_err <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_err <= r_flag;
        end
    end

    assign err = r_err;
`else
    logic w_unusedDigitBad;

    assign r_flag           = 1'b0;
    assign w_unusedDigitBad = w_digitBad;
    assign err              = 1'b0;
`endif

    // Conversion FSM: accept and capture in IDLE, consume one digit per edge in
    // CONV, publish the result in DONE. A start coinciding with the done pulse
    // is dropped so the caller must re-present it.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_binOut <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !r_done) begin
                        r_shreg <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_acc   <= w_accNext;
                    r_shreg <= {r_shreg[SH_W-BCD_W-1:0], {BCD_W{1'b0}}};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DIGITS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_binOut <= r_flag ? '0 : r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_binOut;

endmodule

// File: tb/tb_bcd_to_bin_operand.sv
// Directed testbench for bcd_to_bin_operand at default sizing.
module tb_bcd_to_bin_operand;

    logic        clk;
    logic        reset_p;
    logic        start;
    logic [63:0] bcd_in;
    logic        busy;
    logic        done;
    logic [53:0] bin_out;
    logic        err;

    int          nVectors;
    int          nMiscompares;
    logic [63:0] lastBin;

    bcd_to_bin_operand dut (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Runs one conversion; with disturb set, also re-pulses start mid-conversion,
    // changes bcd_in after accept and asserts start in the done cycle
    task automatic applyStimulus(input logic [63:0] bcd, input logic [63:0] expBin,
                                 input logic expErr, input bit disturb);
        int edges;
        int extra;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (disturb) bcd_in = 64'h9999_9999_9999_9999;
        checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (disturb) begin
                if (edges == 5) start = 1'b1;
                else if (edges == 6) start = 1'b0;
            end
            if (edges == 8) checkOutput("bin_out_held", {10'd0, bin_out}, lastBin);
        end
        checkOutput("done_latency", 64'(edges), 64'd17);
        checkOutput("bin_out", {10'd0, bin_out}, expBin);
        checkOutput("err", {63'd0, err}, {63'd0, expErr});
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        if (disturb) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            extra = 0;
            repeat (25) begin
                if (done === 1'b1 || busy === 1'b1) extra++;
                @(posedge clk);
                #1;
            end
            checkOutput("no_retrigger", 64'(extra), 64'd0);
            checkOutput("bin_out_after_disturb", {10'd0, bin_out}, expBin);
        end else begin
            @(posedge clk);
            #1;
            checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
        end
        lastBin = expBin;
    endtask

    // Directed sequence
    initial begin
        int extra;
        nVectors     = 0;
        nMiscompares = 0;
        lastBin      = 64'd0;
        reset_p      = 1'b1;
        start        = 1'b0;
        bcd_in       = 64'd0;
        #12;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_bin", {10'd0, bin_out}, 64'd0);
        checkOutput("reset_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        reset_p = 1'b0;

        $display("[TB] basic 1234, all nines, zero after 1234");
        applyStimulus(64'h0000_0000_0000_1234, 64'd1234, 1'b0, 1'b0);
        applyStimulus(64'h9999_9999_9999_9999, 64'd9999999999999999, 1'b0, 1'b0);
        applyStimulus(64'h0000_0000_0000_1234, 64'd1234, 1'b0, 1'b0);
        applyStimulus(64'h0000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
        applyStimulus(64'h1000_0000_0000_0001, 64'd1000000000000001, 1'b0, 1'b0);
        applyStimulus(64'h0123_4567_8901_2345, 64'd123456789012345, 1'b0, 1'b0);

        $display("[TB] ignored starts and late bcd_in change");
        applyStimulus(64'h0000_0000_0042_0007, 64'd420007, 1'b0, 1'b1);

        $display("[TB] reset in the middle of a conversion");
        @(negedge clk);
        bcd_in = 64'h0000_0000_0000_5678;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        reset_p = 1'b1;
        #1;
        checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset_done", {63'd0, done}, 64'd0);
        checkOutput("midreset_bin", {10'd0, bin_out}, 64'd0);
        checkOutput("midreset_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checkOutput("no_done_after_reset", 64'(extra), 64'd0);
        lastBin = 64'd0;
        applyStimulus(64'h0000_0000_0000_5678, 64'd5678, 1'b0, 1'b0);

        $display("[TB] non-decimal nibble");
`ifdef BCD2BIN_DIGIT_CHECK_EN
        applyStimulus(64'h0000_0000_0000_00A5, 64'd0, 1'b1, 1'b0);
        applyStimulus(64'h0000_0000_0000_0042, 64'd42, 1'b0, 1'b0);
`else
        applyStimulus(64'h0000_0000_0000_00A5, 64'd105, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
